prga_decrypt: RTL and testbench

- RC4 pseudo-random generation stage, directly downstream of the key-scheduling loop.
- Starts once key scheduling has finished and S holds the scheduled permutation.
- Walks the message: swaps S entries, forms each keystream byte, XORs it with the ciphertext ROM byte, and writes the result to the plaintext RAM.
- Flags whether the decrypted message is all lowercase letters and spaces. The key-search logic uses this flag.

---
 rtl/prga_decrypt.sv | 187 ++++++++++++++++++
 tb/tb_prga_decrypt.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prga_decrypt.sv
// RC4 pseudo-random generation stage.
// Runs after key scheduling has left the S permutation in memory. For each
// message byte it swaps two S entries, forms the keystream byte, XORs it
// with the ciphertext ROM byte and writes the result to the plaintext RAM.
// It also flags whether the whole message is lowercase letters and spaces,
// which the key-search logic uses to recognise a correct key.
//
// Memory model: an address driven in cycle c returns its data, which is
// sampled at the end of cycle c+1. S and the ciphertext ROM are separate
// memories, so the final keystream read and the ciphertext read overlap.
// Every byte takes six cycles:
//   RD_I  -> address S[i+1]
//   CAP_I -> capture S[i], address S[j+S[i]]
//   CAP_J -> capture S[j], write S[i] = S[j]
//   WR_J  -> write S[j] = old S[i]
//   RD_F  -> address S[S[i]+S[j]] and ciphertext[k]
//   CAP_F -> write plaintext[k] = keystream ^ ciphertext
`timescale 1ns/1ps

module prga_decrypt #(
   parameter int MSG_LEN = 32
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_start,
   output logic [7:0] o_s_addr,
   output logic [7:0] o_s_wrdata,
   output logic       o_s_wren,
   input  logic [7:0] i_s_rddata,
   output logic [7:0] o_ct_addr,
   input  logic [7:0] i_ct_rddata,
   output logic [7:0] o_pt_addr,
   output logic [7:0] o_pt_wrdata,
   output logic       o_pt_wren,
   output logic       o_done,
   output logic       o_plain_ok
);

   // Sequencer states, one cycle each except IDLE and DONE.
   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] RD_I  = 3'd1;
   localparam logic [2:0] CAP_I = 3'd2;
   localparam logic [2:0] CAP_J = 3'd3;
   localparam logic [2:0] WR_J  = 3'd4;
   localparam logic [2:0] RD_F  = 3'd5;
   localparam logic [2:0] CAP_F = 3'd6;
   localparam logic [2:0] DONE  = 3'd7;

   // Index of the final message byte. Comparing k against this instead of
   // counting up to MSG_LEN keeps k at 8 bits even for a 256-byte message.
   localparam logic [7:0] LAST_K = 8'(MSG_LEN - 1);

   logic [2:0] r_state;
   logic [7:0] r_i;
   logic [7:0] r_j;
   logic [7:0] r_k;
   logic [7:0] r_si;
   logic [7:0] r_sj;
   logic       r_done;
   logic       r_plain_ok;

   logic [7:0] w_j_next;
   logic [7:0] w_f_addr;
   logic [7:0] w_pt_byte;
   logic       w_is_text;
   logic       w_last_byte;

   // j advances by the S[i] value arriving this cycle; the same sum is the
   // address of S[j], so it is shared between the register and the port.
   assign w_j_next    = r_j + i_s_rddata;
   // Keystream address comes from the latched pre-swap values, no reread.
   assign w_f_addr    = r_si + r_sj;
   assign w_pt_byte   = i_s_rddata ^ i_ct_rddata;
   assign w_is_text   = (w_pt_byte == 8'h20) ||
                        ((w_pt_byte >= 8'h61) && (w_pt_byte <= 8'h7A));
   assign w_last_byte = (r_k == LAST_K);

   // Sequencer and index/value registers. DONE is terminal; only reset
   // leaves it, so a start held high after a run cannot retrigger.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= IDLE;
         r_i        <= 8'd0;
         r_j        <= 8'd0;
         r_k        <= 8'd0;
         r_si       <= 8'd0;
         r_sj       <= 8'd0;
         r_done     <= 1'b0;
         r_plain_ok <= 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_start) begin
                  r_i        <= 8'd0;
                  r_j        <= 8'd0;
                  r_k        <= 8'd0;
                  r_plain_ok <= 1'b1;
                  r_state    <= RD_I;
               end
            end
            RD_I: begin
               r_i     <= r_i + 8'd1;
               r_state <= CAP_I;
            end
            CAP_I: begin
               r_si    <= i_s_rddata;
               r_j     <= w_j_next;
               r_state <= CAP_J;
            end
            CAP_J: begin
               r_sj    <= i_s_rddata;
               r_state <= WR_J;
            end
            WR_J: begin
               r_state <= RD_F;
            end
            RD_F: begin
               r_state <= CAP_F;
            end
            CAP_F: begin
               if (!w_is_text) begin
                  r_plain_ok <= 1'b0;
               end
               if (w_last_byte) begin
                  r_state <= DONE;
               end else begin
                  r_k     <= r_k + 8'd1;
                  r_state <= RD_I;
               end
            end
            DONE: begin
               r_done <= 1'b1;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // Memory ports decoded from the current state. Because they depend only
   // on state and registers (plus the registered memory data), a reset
   // clears every strobe and address immediately.
   always_comb begin
      o_s_addr    = 8'd0;
      o_s_wrdata  = 8'd0;
      o_s_wren    = 1'b0;
      o_ct_addr   = 8'd0;
      o_pt_addr   = 8'd0;
      o_pt_wrdata = 8'd0;
      o_pt_wren   = 1'b0;
      case (r_state)
         RD_I: begin
            o_s_addr = r_i + 8'd1;
         end
         CAP_I: begin
            o_s_addr = w_j_next;
         end
         CAP_J: begin
            o_s_addr   = r_i;
            o_s_wrdata = i_s_rddata;
            o_s_wren   = 1'b1;
         end
         WR_J: begin
            o_s_addr   = r_j;
            o_s_wrdata = r_si;
            o_s_wren   = 1'b1;
         end
         RD_F: begin
            o_s_addr  = w_f_addr;
            o_ct_addr = r_k;
         end
         CAP_F: begin
            o_pt_addr   = r_k;
            o_pt_wrdata = w_pt_byte;
            o_pt_wren   = 1'b1;
         end
         default: begin
            o_s_addr = 8'd0;
         end
      endcase
   end

   assign o_done     = r_done;
   assign o_plain_ok = r_plain_ok;

endmodule

// File: tb/tb_prga_decrypt.sv
// Testbench for prga_decrypt.
// Three instances (MSG_LEN 9, 4 and 256) each get their own S memory,
// ciphertext ROM and plaintext RAM with one cycle of read latency. Results
// are compared against constant vectors and against a plain RC4 model.
`timescale 1ns/1ps

module tb_prga_decrypt;

   localparam int NINST = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rstN     [NINST];
   logic       start    [NINST];
   logic       loadReq  [NINST];
   logic [7:0] sRddata  [NINST];
   logic [7:0] ctRddata [NINST];

   wire [7:0] sAddr    [NINST];
   wire [7:0] sWrdata  [NINST];
   wire       sWren    [NINST];
   wire [7:0] ctAddr   [NINST];
   wire [7:0] ptAddr   [NINST];
   wire [7:0] ptWrdata [NINST];
   wire       ptWren   [NINST];
   wire       doneOut  [NINST];
   wire       plainOk  [NINST];

   logic [7:0] sMem  [NINST][256];
   logic [7:0] sInit [NINST][256];
   logic [7:0] ctMem [NINST][256];
   logic [7:0] ptMem [NINST][256];

   logic [7:0] expPt [256];
   logic [7:0] expS  [256];
   logic       expOk;

   int checkCount = 0;
   int passCount  = 0;

   for (genvar g = 0; g < NINST; g++) begin : gInst
      prga_decrypt #(.MSG_LEN(g == 0 ? 9 : (g == 1 ? 4 : 256))) uDut (
         .i_clk       (clk),
         .i_rst_n     (rstN[g]),
         .i_start     (start[g]),
         .o_s_addr    (sAddr[g]),
         .o_s_wrdata  (sWrdata[g]),
         .o_s_wren    (sWren[g]),
         .i_s_rddata  (sRddata[g]),
         .o_ct_addr   (ctAddr[g]),
         .i_ct_rddata (ctRddata[g]),
         .o_pt_addr   (ptAddr[g]),
         .o_pt_wrdata (ptWrdata[g]),
         .o_pt_wren   (ptWren[g]),
         .o_done      (doneOut[g]),
         .o_plain_ok  (plainOk[g])
      );
   end

   // Synchronous memories for every instance; a load request copies the
   // initial S image in and poisons the plaintext RAM.
   always @(posedge clk) begin
      for (int g = 0; g < NINST; g++) begin
         if (loadReq[g]) begin
            for (int a = 0; a < 256; a++) begin
               sMem[g][a]  <= sInit[g][a];
               ptMem[g][a] <= 8'hEE;
            end
         end else begin
            if (sWren[g] === 1'b1) sMem[g][sAddr[g]] <= sWrdata[g];
            if (ptWren[g] === 1'b1) ptMem[g][ptAddr[g]] <= ptWrdata[g];
         end
         sRddata[g]  <= sMem[g][sAddr[g]];
         ctRddata[g] <= ctMem[g][ctAddr[g]];
      end
   end

   typedef struct {
      string       name;
      bit          keyed;
      logic [71:0] ct;
      logic [71:0] pt;
      bit          ok;
   } vecT;

   localparam logic [71:0] KEYCT = 72'hBBF316E8D940AF0AD3;
   localparam logic [71:0] IDKS  = 72'h0205070D0D171F2828;

   vecT vecs [7];

   function automatic int lenOf(input int inst);
      return (inst == 0) ? 9 : ((inst == 1) ? 4 : 256);
   endfunction

   function automatic logic [7:0] byteOf(input logic [71:0] v, input int n);
      return v[8 * (8 - n) +: 8];
   endfunction

   function automatic bit isText(input logic [7:0] b);
      return (b == 8'h20) || (b >= 8'h61 && b <= 8'h7A);
   endfunction

   task automatic checkOutput(input string name, input logic [71:0] actual,
                              input logic [71:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
   endtask

   // Textbook RC4 output generation over the bench's own S image and ROM.
   task automatic rc4Model(input int inst);
      logic [7:0] s [256];
      logic [7:0] tmp;
      int i = 0;
      int j = 0;
      for (int a = 0; a < 256; a++) s[a] = sInit[inst][a];
      expOk = 1'b1;
      for (int n = 0; n < 256; n++) expPt[n] = 8'hEE;
      for (int n = 0; n < lenOf(inst); n++) begin
         i = (i + 1) % 256;
         j = (j + int'(s[i])) % 256;
         tmp = s[i]; s[i] = s[j]; s[j] = tmp;
         expPt[n] = ctMem[inst][n] ^ s[(int'(s[i]) + int'(s[j])) % 256];
         if (!isText(expPt[n])) expOk = 1'b0;
      end
      for (int a = 0; a < 256; a++) expS[a] = s[a];
   endtask

   task automatic ksaKeyInit(input int inst);
      logic [7:0] key [3];
      logic [7:0] tmp;
      int j = 0;
      key[0] = 8'h4B; key[1] = 8'h65; key[2] = 8'h79;
      for (int a = 0; a < 256; a++) sInit[inst][a] = 8'(a);
      for (int a = 0; a < 256; a++) begin
         j = (j + int'(sInit[inst][a]) + int'(key[a % 3])) % 256;
         tmp = sInit[inst][a]; sInit[inst][a] = sInit[inst][j]; sInit[inst][j] = tmp;
      end
   endtask

   task automatic identityInit(input int inst);
      for (int a = 0; a < 256; a++) sInit[inst][a] = 8'(a);
   endtask

   task automatic randomPermInit(input int inst);
      logic [7:0] tmp;
      int r;
      identityInit(inst);
      for (int a = 255; a > 0; a--) begin
         r = int'($urandom_range(0, a));
         tmp = sInit[inst][a]; sInit[inst][a] = sInit[inst][r]; sInit[inst][r] = tmp;
      end
   endtask

   task automatic resetInst(input int inst);
      @(negedge clk);
      start[inst] = 1'b0;
      rstN[inst]  = 1'b0;
      repeat (2) @(negedge clk);
      rstN[inst]  = 1'b1;
      @(negedge clk);
   endtask

   task automatic loadMemories(input int inst);
      @(negedge clk);
      loadReq[inst] = 1'b1;
      @(negedge clk);
      loadReq[inst] = 1'b0;
   endtask

   // Raises start and follows the run for exactly 6*len+2 cycles, checking
   // strobe cadence, write order and the done latency along the way.
   task automatic applyStimulus(input int inst, input int dropAt, input string tag);
      int len = lenOf(inst);
      int protoErr = 0;
      int pulses = 0;
      int expAddr = 0;
      int ph;
      logic doneBefore = 1'b0;
      logic doneAfter = 1'b0;
      @(negedge clk);
      start[inst] = 1'b1;
      for (int n = 1; n <= 6 * len + 2; n++) begin
         @(negedge clk);
         if (n == dropAt) start[inst] = 1'b0;
         if (n <= 6 * len) begin
            ph = (n - 1) % 6;
            if (sWren[inst] !== (ph == 2 || ph == 3)) protoErr++;
            if (ptWren[inst] !== (ph == 5)) protoErr++;
            if (ph == 5) begin
               if (ptAddr[inst] !== 8'(expAddr)) protoErr++;
               expAddr++;
            end
         end else if (sWren[inst] !== 1'b0 || ptWren[inst] !== 1'b0) begin
            protoErr++;
         end
         if (n <= 6 * len && doneOut[inst] !== 1'b0) protoErr++;
         if (ptWren[inst] === 1'b1) pulses++;
         if (n == 6 * len + 1) doneBefore = doneOut[inst];
         if (n == 6 * len + 2) doneAfter = doneOut[inst];
      end
      checkOutput({tag, " protocol errors"}, 72'(protoErr), 72'(0));
      checkOutput({tag, " pt_wren pulses"}, 72'(pulses), 72'(len));
      checkOutput({tag, " done at 6N+1"}, 72'({doneBefore, doneAfter}), 72'(2'b01));
   endtask

   // Compares plaintext RAM, final S and plain_ok with the RC4 model.
   task automatic checkAgainstModel(input int inst, input string tag);
      int ptErr = 0;
      int sErr = 0;
      for (int n = 0; n < lenOf(inst); n++) if (ptMem[inst][n] !== expPt[n]) ptErr++;
      for (int a = 0; a < 256; a++) if (sMem[inst][a] !== expS[a]) sErr++;
      checkOutput({tag, " pt bytes wrong"}, 72'(ptErr), 72'(0));
      checkOutput({tag, " S entries wrong"}, 72'(sErr), 72'(0));
      checkOutput({tag, " plain_ok"}, 72'(plainOk[inst]), 72'(expOk));
   endtask

   initial begin
      logic [71:0] act;
      int idleWr;
      int idleDone;
      logic [7:0] want [256];
      bit textMode;
      int r;

      for (int g = 0; g < NINST; g++) begin
         rstN[g] = 1'b0;
         start[g] = 1'b0;
         loadReq[g] = 1'b0;
         for (int a = 0; a < 256; a++) begin
            ctMem[g][a] = 8'h00;
            sInit[g][a] = 8'(a);
         end
      end

      vecs[0] = '{"key Plaintext", 1'b1, KEYCT, 72'h506C61696E74657874, 1'b0};
      vecs[1] = '{"key plaintext", 1'b1, KEYCT ^ 72'h506C61696E74657874 ^ 72'h706C61696E74657874,
                  72'h706C61696E74657874, 1'b1};
      vecs[2] = '{"ident zero ct", 1'b0, 72'h0, IDKS, 1'b0};
      vecs[3] = '{"ident a-z space", 1'b0, IDKS ^ 72'h6162632078797A2071, 72'h6162632078797A2071, 1'b1};
      vecs[4] = '{"ident 0x7B last", 1'b0, IDKS ^ 72'h61626364656667687B, 72'h61626364656667687B, 1'b0};
      vecs[5] = '{"ident 0x60 first", 1'b0, IDKS ^ 72'h606263646566676869, 72'h606263646566676869, 1'b0};
      vecs[6] = '{"ident 0x21", 1'b0, IDKS ^ 72'h612163646566676869, 72'h612163646566676869, 1'b0};

      repeat (3) @(negedge clk);
      checkOutput("reset outputs",
                  72'({sAddr[0], sWrdata[0], sWren[0], ctAddr[0], ptAddr[0],
                       ptWrdata[0], ptWren[0], doneOut[0], plainOk[0]}), 72'(44'h1));
      for (int g = 0; g < NINST; g++) rstN[g] = 1'b1;

      // start held low: nothing may happen
      idleWr = 0;
      idleDone = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (sWren[0] !== 1'b0 || ptWren[0] !== 1'b0) idleWr++;
         if (doneOut[0] !== 1'b0) idleDone++;
      end
      checkOutput("idle write strobes", 72'(idleWr), 72'(0));
      checkOutput("idle done", 72'(idleDone), 72'(0));

      // table-driven vectors on the 9-byte instance
      for (int v = 0; v < 7; v++) begin
         resetInst(0);
         if (vecs[v].keyed) ksaKeyInit(0);
         else identityInit(0);
         for (int n = 0; n < 9; n++) ctMem[0][n] = byteOf(vecs[v].ct, n);
         loadMemories(0);
         rc4Model(0);
         applyStimulus(0, 0, vecs[v].name);
         act = '0;
         for (int n = 0; n < 9; n++) act = {act[63:0], ptMem[0][n]};
         checkOutput({vecs[v].name, " pt"}, act, vecs[v].pt);
         checkOutput({vecs[v].name, " plain_ok"}, 72'(plainOk[0]), 72'(vecs[v].ok));
         checkAgainstModel(0, vecs[v].name);
      end

      // 4-byte instance on identity S, then start held high after done
      resetInst(1);
      identityInit(1);
      for (int n = 0; n < 256; n++) ctMem[1][n] = 8'h00;
      loadMemories(1);
      rc4Model(1);
      applyStimulus(1, 0, "ident4");
      checkOutput("ident4 first pt byte", 72'(ptMem[1][0]), 72'(8'h02));
      checkOutput("ident4 pt", 72'({ptMem[1][0], ptMem[1][1], ptMem[1][2], ptMem[1][3]}),
                  72'(32'h0205070D));
      checkOutput("ident4 S[1] after i==j swap", 72'(sMem[1][1]), 72'(8'h01));
      checkAgainstModel(1, "ident4");
      idleWr = 0;
      idleDone = 0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (sWren[1] !== 1'b0 || ptWren[1] !== 1'b0) idleWr++;
         if (doneOut[1] !== 1'b1) idleDone++;
      end
      checkOutput("ident4 no rerun strobes", 72'(idleWr), 72'(0));
      checkOutput("ident4 done held", 72'(idleDone), 72'(0));

      // reset during WR_J of the third byte, then a clean rerun
      resetInst(0);
      ksaKeyInit(0);
      for (int n = 0; n < 9; n++) ctMem[0][n] = byteOf(KEYCT, n);
      loadMemories(0);
      @(negedge clk);
      start[0] = 1'b1;
      repeat (16) @(negedge clk);
      checkOutput("midrun s_wren in WR_J", 72'(sWren[0]), 72'(1'b1));
      #1 rstN[0] = 1'b0;
      #1;
      checkOutput("midrun outputs after reset",
                  72'({sAddr[0], sWrdata[0], sWren[0], ctAddr[0], ptAddr[0],
                       ptWrdata[0], ptWren[0], doneOut[0], plainOk[0]}), 72'(44'h1));
      start[0] = 1'b0;
      repeat (2) @(negedge clk);
      rstN[0] = 1'b1;
      loadMemories(0);
      rc4Model(0);
      applyStimulus(0, 0, "rerun after reset");
      checkAgainstModel(0, "rerun after reset");

      // randomized runs, start dropped early, half aimed at text plaintext
      for (int t = 0; t < 6; t++) begin
         int inst = (t < 4) ? 0 : 2;
         textMode = (t % 2) == 1;
         resetInst(inst);
         randomPermInit(inst);
         for (int n = 0; n < 256; n++) ctMem[inst][n] = 8'($urandom_range(0, 255));
         if (textMode) begin
            for (int n = 0; n < 256; n++) ctMem[inst][n] = 8'h00;
            rc4Model(inst);
            for (int n = 0; n < lenOf(inst); n++) begin
               r = int'($urandom_range(0, 26));
               want[n] = (r == 26) ? 8'h20 : 8'(8'h61 + r);
               ctMem[inst][n] = expPt[n] ^ want[n];
            end
         end
         loadMemories(inst);
         rc4Model(inst);
         applyStimulus(inst, int'($urandom_range(1, 20)), $sformatf("random%0d", t));
         checkAgainstModel(inst, $sformatf("random%0d", t));
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
